// File: rtl/id_stage_pkg.sv
// Shared definitions for the decode stage: opcodes, instruction field layout, slot states.
// No logic; pure constants, types and a field-extract helper.
package id_stage_pkg;
  localparam int RIDX_W  = 3;
  localparam int OPC_W   = 3;
  localparam int INSTR_W = 12;

  localparam int OPC_LSB = 9;
  localparam int RD_LSB  = 6;
  localparam int RS_LSB  = 3;
  localparam int RT_LSB  = 0;

  localparam logic [OPC_W-1:0] OP_AND = 3'b000;
  localparam logic [OPC_W-1:0] OP_ADD = 3'b001;
  localparam logic [OPC_W-1:0] OP_SLL = 3'b010;
  localparam logic [OPC_W-1:0] OP_SRL = 3'b011;
  localparam logic [OPC_W-1:0] OP_SUB = 3'b100;
  localparam logic [OPC_W-1:0] OP_SLT = 3'b101;
  localparam logic [OPC_W-1:0] OP_ABS = 3'b110;
  localparam logic [OPC_W-1:0] OP_SEQ = 3'b111;

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_t;

  // All instruction fields are 3 bits wide, so one extractor serves every field.
  function automatic logic [RIDX_W-1:0] field(input logic [INSTR_W-1:0] instr, input int lsb);
    return instr[lsb +: RIDX_W];
  endfunction
endpackage

// File: rtl/id_stage_regfile.sv
// Register file, 2 read / 1 write; r0 hard-wired to zero.
// Latency: reads combinational with same-cycle writeback bypass; write lands on clk edge.
// Backpressure: none, always accepts writes.
module id_stage_regfile
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RIDX_W-1:0] ra_idx,
  input  logic [RIDX_W-1:0] rb_idx,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              wr_en,
  input  logic [RIDX_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data
);
  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en && (wr_idx != '0)) begin
      regs[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    ra_data = regs[ra_idx];
    if (ra_idx == '0)                      ra_data = '0;
    else if (wr_en && (wr_idx == ra_idx))  ra_data = wr_data;
  end

  always_comb begin
    rb_data = regs[rb_idx];
    if (rb_idx == '0)                      rb_data = '0;
    else if (wr_en && (wr_idx == rb_idx))  rb_data = wr_data;
  end
endmodule

// File: rtl/id_stage.sv
// Decode/issue stage: operand read, pending-register scoreboard, one-entry output slot.
// Latency: 1 cycle accept-to-output; full throughput when hazard-free.
// Backpressure: instr_ready_o drops on a source hazard or when the full slot is not drained.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  output logic [DATA_W-1:0]  rs_o,
  output logic [DATA_W-1:0]  rt_o,
  output logic [OPC_W-1:0]   opcode_o,
  output logic [RIDX_W-1:0]  rd_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  input  logic               wb_en_i,
  input  logic [RIDX_W-1:0]  wb_idx_i,
  input  logic [DATA_W-1:0]  wb_data_i
);
  logic [OPC_W-1:0]  opcode;
  logic [RIDX_W-1:0] rd, rs, rt;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic [NREG-1:0]   pending, pending_nxt;
  logic              wb_act, rs_haz, rt_haz, accept, load;
  slot_state_t       state, state_nxt;

  assign opcode = field(instr_i, OPC_LSB);
  assign rd     = field(instr_i, RD_LSB);
  assign rs     = field(instr_i, RS_LSB);
  assign rt     = field(instr_i, RT_LSB);

  assign wb_act = wb_en_i && !rst && (wb_idx_i != '0);

  id_stage_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_idx  (rs),
    .rb_idx  (rt),
    .ra_data (rs_val),
    .rb_data (rt_val),
    .wr_en   (wb_act),
    .wr_idx  (wb_idx_i),
    .wr_data (wb_data_i)
  );

  // A writeback landing this cycle resolves the hazard it would otherwise cause.
  assign rs_haz = pending[rs] && !(wb_act && (wb_idx_i == rs));
  assign rt_haz = pending[rt] && !(wb_act && (wb_idx_i == rt));

  assign out_valid_o   = (state == SLOT_FULL);
  assign instr_ready_o = !(rs_haz || rt_haz) && (!out_valid_o || out_ready_i);
  assign accept        = instr_valid_i && instr_ready_o && !rst;

  // Set after clear so a re-issue to the register being written back stays pending.
  always_comb begin
    pending_nxt = pending;
    if (wb_act)                   pending_nxt[wb_idx_i] = 1'b0;
    if (accept && (rd != '0))     pending_nxt[rd]       = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      SLOT_EMPTY: begin
        if (accept) begin
          state_nxt = SLOT_FULL;
          load      = 1'b1;
        end
      end
      SLOT_FULL: begin
        if (accept)           load      = 1'b1;
        else if (out_ready_i) state_nxt = SLOT_EMPTY;
      end
      default: state_nxt = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SLOT_EMPTY;
      pending  <= '0;
      rs_o     <= '0;
      rt_o     <= '0;
      opcode_o <= '0;
      rd_o     <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (load) begin
        rs_o     <= rs_val;
        rt_o     <= rt_val;
        opcode_o <= opcode;
        rd_o     <= rd;
      end
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected outputs queued at issue, popped on output handshake.
module tb_id_stage;
  import id_stage_pkg::*;

  typedef struct packed {
    logic [7:0] rs;
    logic [7:0] rt;
    logic [2:0] opc;
    logic [2:0] rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [7:0]  rs_o, rt_o;
  logic [2:0]  opcode_o, rd_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        wb_en_i;
  logic [2:0]  wb_idx_i;
  logic [7:0]  wb_data_i;

  int n_cmp = 0;
  int n_err = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  id_stage #(.DATA_W(8), .NREG(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .rs_o          (rs_o),
    .rt_o          (rt_o),
    .opcode_o      (opcode_o),
    .rd_o          (rd_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .wb_en_i       (wb_en_i),
    .wb_idx_i      (wb_idx_i),
    .wb_data_i     (wb_data_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] enc(input logic [2:0] opc, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt);
    return {opc, rd, rs, rt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic [2:0] opc, input logic [2:0] rd,
                             input logic [2:0] rs, input logic [2:0] rt);
    instr_i       = enc(opc, rd, rs, rt);
    instr_valid_i = 1'b1;
  endtask

  task automatic wb(input logic en, input logic [2:0] idx, input logic [7:0] dat);
    wb_en_i   = en;
    wb_idx_i  = idx;
    wb_data_i = dat;
  endtask

  // Output handshake completes on the next rising edge; sample mid-cycle.
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 32'(q.size()), 32'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_slot", {10'd0, rs_o, rt_o, opcode_o, rd_o}, {10'd0, e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; instr_i = '0; instr_valid_i = 1'b0; out_ready_i = 1'b1;
    wb(1'b0, 3'd0, 8'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_rs", 32'(rs_o), 32'd0);
    chk("rst_rt", 32'(rt_o), 32'd0);
    chk("rst_opc_rd", {26'd0, opcode_o, rd_o}, 32'd0);
    chk("rst_ready", 32'(instr_ready_o), 32'd1);

    wb(1'b1, 3'd1, 8'd20);  tick();
    wb(1'b1, 3'd2, 8'd100); tick();
    wb(1'b0, 3'd0, 8'd0);

    // ADD r3,r1,r2
    drive_instr(OP_ADD, 3'd3, 3'd1, 3'd2); #1;
    chk("add_ready", 32'(instr_ready_o), 32'd1);
    q.push_back('{rs: 8'd20, rt: 8'd100, opc: OP_ADD, rd: 3'd3});
    tick();
    chk("add_out_valid", 32'(out_valid_o), 32'd1);
    chk("add_rs_direct", 32'(rs_o), 32'd20);

    // SUB r4,r3,r1 stalls on pending r3 until writeback
    drive_instr(OP_SUB, 3'd4, 3'd3, 3'd1); #1;
    chk("sub_hazard_ready", 32'(instr_ready_o), 32'd0);
    tick();
    chk("sub_hazard_ready2", 32'(instr_ready_o), 32'd0);
    chk("drain_out_valid", 32'(out_valid_o), 32'd0);
    wb(1'b1, 3'd3, 8'd120); #1;
    chk("sub_wb_ready", 32'(instr_ready_o), 32'd1);
    q.push_back('{rs: 8'd120, rt: 8'd20, opc: OP_SUB, rd: 3'd4});
    tick();
    wb(1'b0, 3'd0, 8'd0);

    // Output stall for 3 cycles, then release with ADD r5,r1,r1 pending
    out_ready_i = 1'b0;
    drive_instr(OP_ADD, 3'd5, 3'd1, 3'd1); #1;
    chk("stall_ready0", 32'(instr_ready_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", {10'd0, rs_o, rt_o, opcode_o, rd_o},
          {10'd0, 8'd120, 8'd20, OP_SUB, 3'd4});
      chk("stall_valid", 32'(out_valid_o), 32'd1);
      chk("stall_ready", 32'(instr_ready_o), 32'd0);
    end
    out_ready_i = 1'b1; #1;
    chk("release_ready", 32'(instr_ready_o), 32'd1);
    q.push_back('{rs: 8'd20, rt: 8'd20, opc: OP_ADD, rd: 3'd5});
    tick();

    // Writeback to r0 is ignored, even as a bypass
    wb(1'b1, 3'd0, 8'hFF);
    drive_instr(OP_AND, 3'd6, 3'd0, 3'd0); #1;
    chk("r0_ready", 32'(instr_ready_o), 32'd1);
    q.push_back('{rs: 8'd0, rt: 8'd0, opc: OP_AND, rd: 3'd0 + 3'd6});
    tick();
    wb(1'b0, 3'd0, 8'd0);

    // Back-to-back hazard-free stream; r1=20 r2=100 r3=120
    for (int i = 0; i < 5; i++) begin
      logic [2:0] s, t;
      logic [7:0] sv, tv;
      s  = 3'(1 + (i % 3));
      t  = 3'(1 + ((i + 1) % 3));
      sv = (s == 3'd1) ? 8'd20 : (s == 3'd2) ? 8'd100 : 8'd120;
      tv = (t == 3'd1) ? 8'd20 : (t == 3'd2) ? 8'd100 : 8'd120;
      drive_instr(3'(i), 3'd7, s, t); #1;
      chk("stream_ready", 32'(instr_ready_o), 32'd1);
      q.push_back('{rs: sv, rt: tv, opc: 3'(i), rd: 3'd7});
      tick();
      chk("stream_valid", 32'(out_valid_o), 32'd1);
    end
    instr_valid_i = 1'b0;
    tick();
    chk("stream_drained", 32'(q.size()), 32'd0);
    chk("stream_empty", 32'(out_valid_o), 32'd0);

    // Reset with slot full and r2 pending discards everything
    out_ready_i = 1'b0;
    drive_instr(OP_SLT, 3'd2, 3'd1, 3'd1); #1;
    chk("pre_rst_ready", 32'(instr_ready_o), 32'd1);
    tick();
    chk("pre_rst_full", 32'(out_valid_o), 32'd1);
    rst = 1'b1; out_ready_i = 1'b1;
    wb(1'b1, 3'd1, 8'h55);
    drive_instr(OP_SEQ, 3'd5, 3'd1, 3'd1);
    tick();
    rst = 1'b0; instr_valid_i = 1'b0;
    wb(1'b0, 3'd0, 8'd0); #1;
    chk("post_rst_valid", 32'(out_valid_o), 32'd0);
    chk("post_rst_ready", 32'(instr_ready_o), 32'd1);
    chk("post_rst_outs", {10'd0, rs_o, rt_o, opcode_o, rd_o}, 32'd0);
    drive_instr(OP_ADD, 3'd3, 3'd1, 3'd2); #1;
    chk("post_rst_no_hazard", 32'(instr_ready_o), 32'd1);
    q.push_back('{rs: 8'd0, rt: 8'd0, opc: OP_ADD, rd: 3'd3});
    tick();
    instr_valid_i = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
